// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared seven-segment glyphs, scan states and digit indices
package count_disp_pkg;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

  localparam logic [1:0] DIG_CNT  = 2'd0;
  localparam logic [1:0] DIG_ONES = 2'd1;
  localparam logic [1:0] DIG_TENS = 2'd2;
  localparam logic [1:0] DIG_OVF  = 2'd3;

endpackage

// File: rtl/count_seg_scan_if.sv
// rtl/count_seg_scan_if.sv - counter input, wrap count and display signals of count_seg_scan
interface count_seg_scan_if;
  logic [3:0] cnt_in;
  logic       clr;
  logic       wrap_pulse;
  logic [3:0] wrap_tens;
  logic [3:0] wrap_ones;
  logic       ovf;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output cnt_in, clr,
    input  wrap_pulse, wrap_tens, wrap_ones, ovf, an, seg
  );

  modport slave (
    input  cnt_in, clr,
    output wrap_pulse, wrap_tens, wrap_ones, ovf, an, seg
  );
endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational 4-bit hex to active-low seven-segment decoder
module hex_to_seg7
  import count_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_seg_scan.sv
// rtl/count_seg_scan.sv - counter wrap detector, BCD wrap count and 4-digit display scanner
module count_seg_scan
  import count_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  count_seg_scan_if.slave  bus
);

  localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

  logic [3:0]  cnt_q;
  logic        wrap_pulse_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;
  logic        ovf_q;
  logic        wrap_det;

  scan_state_t state, state_n;
  logic [15:0] presc, presc_n;
  logic [1:0]  idx, idx_n;

  logic [3:0]  digit_hex;
  logic [6:0]  digit_glyph;

  // Only an exact F->0 step counts; jumps and holds at F are ignored
  assign wrap_det = (cnt_q == 4'hF) && (bus.cnt_in == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 4'h0;
      wrap_pulse_q <= 1'b0;
      tens_q       <= 4'h0;
      ones_q       <= 4'h0;
      ovf_q        <= 1'b0;
    end else begin
      cnt_q        <= bus.cnt_in;
      wrap_pulse_q <= wrap_det;
      if (bus.clr) begin
        tens_q <= 4'h0;
        ones_q <= 4'h0;
        ovf_q  <= 1'b0;
      end else if (wrap_det) begin
        if (ones_q == 4'd9) begin
          ones_q <= 4'h0;
          if (tens_q == 4'd9) begin
            tens_q <= 4'h0;
            ovf_q  <= 1'b1;
          end else begin
            tens_q <= tens_q + 4'd1;
          end
        end else begin
          ones_q <= ones_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SHOW;
      presc <= 16'h0;
      idx   <= 2'd0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    idx_n   = idx;
    case (state)
      ST_SHOW: begin
        if (presc == PRESC_LAST) begin
          presc_n = 16'h0;
          state_n = ST_BLANK;
        end else begin
          presc_n = presc + 16'd1;
        end
      end
      ST_BLANK: begin
        state_n = ST_SHOW;
        idx_n   = idx + 2'd1;
      end
      default: state_n = ST_SHOW;
    endcase
  end

  always_comb begin
    digit_hex = 4'hF;
    case (idx)
      DIG_CNT:  digit_hex = cnt_q;
      DIG_ONES: digit_hex = ones_q;
      DIG_TENS: digit_hex = tens_q;
      DIG_OVF:  digit_hex = 4'hF;
      default:  digit_hex = 4'hF;
    endcase
  end

  hex_to_seg7 u_dec (
    .hex (digit_hex),
    .seg (digit_glyph)
  );

  // Display is forced dark while rst is held, then driven straight from state
  always_comb begin
    bus.an  = 4'hF;
    bus.seg = SEG_BLANK;
    if (!rst && state == ST_SHOW) begin
      bus.an  = ~(4'b0001 << idx);
      bus.seg = (idx == DIG_OVF && !ovf_q) ? SEG_BLANK : digit_glyph;
    end
  end

  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.wrap_tens  = tens_q;
  assign bus.wrap_ones  = ones_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: doc/count_seg_scan.md
Name: count_seg_scan

Overview:
- Downstream consumer of the 4-bit synchronous up counter. Registers the counter value and detects each exact 15->0 wrap.
- Accumulates wraps in a 2-digit BCD counter (00-99) with a sticky overflow flag.
- Time-multiplexes a 4-digit common-anode seven-segment display: hex count, wrap ones, wrap tens, overflow indicator.

Parameters:
- REFRESH_DIV, 4, cycles each digit stays lit before the blank gap. Legal range 2..65535; the bench uses the default, the board build uses 50000.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high; clears every register.
- cnt_in  in  4  counter value from the up counter, {Q3,Q2,Q1,Q0}; same clock domain, no synchroniser.
- clr  in  1  synchronous clear of the wrap count and overflow flag. Lower priority than rst.
- wrap_pulse  out  1  one-cycle pulse per detected 15->0 wrap.
- wrap_tens  out  4  BCD tens of the wrap count.
- wrap_ones  out  4  BCD ones of the wrap count.
- ovf  out  1  sticky; set when the wrap count rolls 99->00.
- an  out  4  digit enables, active-low; an[i]=0 lights digit i.
- seg  out  7  segments, active-low; seg[0]=a .. seg[6]=g.

Behaviour:
- Reset values:
  - cnt_q=0, wrap_pulse=0, wrap_tens=0, wrap_ones=0, ovf=0.
  - prescaler=0, digit index=0, state=SHOW.
  - an=4'hF and seg=7'h7F for the reset cycle. The first SHOW cycle after rst deasserts lights digit0.
- Reset mid-operation: the same values apply on the next edge. No partial-state carry-over.
- Sampling: cnt_q <= cnt_in on every edge.
- Wrap detect:
  - At an edge where cnt_q==4'hF and cnt_in==4'h0: wrap_pulse<=1 and the BCD count increments on that same edge.
  - Otherwise wrap_pulse<=0.
  - Latency: 1 cycle after the counter shows 0.
  - Any other transition, including a jump such as F->3 or a hold at F, is not a wrap.
- BCD increment:
  - ones 9->0 carries into tens.
  - 99 -> 00 and sets ovf. ovf stays set until rst or clr.
  - ones and tens never leave 0..9.
- Precedence for the wrap count:
  1. rst.
  2. clr: wrap count 00, ovf 0. A wrap on the same edge is discarded, but wrap_pulse still asserts.
  3. Increment.
- Scan FSM, two states:
  - SHOW: prescaler increments each cycle. When it reaches REFRESH_DIV-1: prescaler<=0 and go to BLANK.
  - BLANK: lasts exactly 1 cycle, with an=4'hF and seg=7'h7F. Then go to SHOW with index<=(index+1) mod 4.
  - Digit period is REFRESH_DIV+1 cycles; a full frame is 4*(REFRESH_DIV+1).
- Outputs in SHOW with index i:
  - an = ~(4'b0001<<i).
  - seg = glyph for digit i, decoded from the current registers with no extra latency.
- Digit sources:
  - digit0 = cnt_q as hex.
  - digit1 = wrap_ones.
  - digit2 = wrap_tens.
  - digit3 = "F" if ovf, else blank (7'h7F).
- Glyphs (hex 0-F, standard shapes): 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E, blank=7'h7F.
- Displayed values may change mid-digit. No frame latching.

Decomposition:
- Shared package count_disp_pkg holds:
  - the seven-segment glyph constants (SEG_0..SEG_F, SEG_BLANK);
  - the scan state encoding (ST_SHOW, ST_BLANK);
  - the digit-index constants.
- One sub-module, hex_to_seg7: combinational 4-bit to 7-bit active-low decoder, also reused by later display blocks.
- The BCD counter and scan FSM stay inline.

Test Plan:
- Reset: hold rst for 3 cycles with cnt_in=4'h7 -> an=4'hF, seg=7'h7F, wrap_pulse=0, tens=ones=0, ovf=0. After release, the first SHOW cycle has an=4'b1110.
- Counter sweep: drive 0..F then 0 -> wrap_pulse high for exactly the 1 cycle after cnt_in goes to 0, ones=1, tens=0. A repeat of 10 wraps gives tens=1, ones=0.
- False-wrap rejection: drive F->3, F->F->F, and E->0 -> wrap_pulse never asserts and the count is unchanged.
- Overflow: apply 100 wraps -> tens=0, ones=0, ovf=1. During digit3 SHOW, seg=7'h0E and an=4'b0111. A clr pulse gives ovf=0 and digit3 seg=7'h7F.
- clr with a coincident wrap: cnt_q=F, cnt_in=0, clr=1 on the same edge -> wrap_pulse=1, count=00.
- Scan timing (REFRESH_DIV=4): an sequence is 1110 x4, 1111 x1, 1101 x4, 1111 x1, 1011 x4, 1111 x1, 0111 x4, 1111 x1, repeating every 20 cycles. With cnt_in=4'hA, seg=7'h08 during digit0.
